// File: rtl/muldiv_if.sv
// Request/result bundle between the EX-stage control and the multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: magnitudes are processed unsigned
// over WIDTH iterations, then the result signs are restored in a final fix-up cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return (~x) + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] x, input logic en);
    return en ? neg_w(x) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] x, input logic en);
    return en ? ((~x) + (2*WIDTH)'(1)) : x;
  endfunction

  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? neg_w(x) : x;
  endfunction

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   ua_q, ua_d;
  logic [WIDTH-1:0]   ub_q, ub_d;
  logic [WIDTH-1:0]   araw_q, araw_d;
  logic               negp_q, negp_d;
  logic               negr_q, negr_d;
  logic               bz_q, bz_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic               in_signed;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     shl;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;

  assign in_signed = ~bus.op[0];
  assign abs_a     = abs_w(bus.a, in_signed);
  assign abs_b     = abs_w(bus.b, in_signed);

  // Multiply: acc holds {partial product, remaining multiplier bits}; add then shift right.
  assign msum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? ua_q : '0)};
  assign mul_next = {msum, acc_q[WIDTH-1:1]};

  // Divide: acc holds {remainder, dividend/quotient}; remainder < divisor keeps diff[WIDTH] a true borrow.
  assign shl      = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign diff     = shl - {1'b0, ub_q};
  assign div_next = diff[WIDTH] ? {shl[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign prod_fix = cneg_2w(acc_q, negp_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    ua_d    = ua_q;
    ub_d    = ub_q;
    araw_d  = araw_q;
    negp_d  = negp_q;
    negr_d  = negr_q;
    bz_d    = bz_q;
    acc_d   = acc_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          ua_d    = abs_a;
          ub_d    = abs_b;
          araw_d  = bus.a;
          negp_d  = in_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          negr_d  = in_signed & bus.a[WIDTH-1];
          bz_d    = (bus.b == '0);
          acc_d   = {{WIDTH{1'b0}}, (bus.op[1] ? abs_a : abs_b)};
          cnt_d   = '0;
          state_d = S_CALC;
        end else begin
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
        end
      end
      S_CALC: begin
        acc_d = op_q[1] ? div_next : mul_next;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (op_q[1]) begin
          if (bz_q) begin
            hi_d  = araw_q;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            lo_d = cneg_w(acc_q[WIDTH-1:0], negp_q);
            hi_d = cneg_w(acc_q[2*WIDTH-1:WIDTH], negr_q);
          end
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q   <= op_d;
    ua_q   <= ua_d;
    ub_q   <= ub_d;
    araw_q <= araw_d;
    negp_q <= negp_d;
    negr_q <= negr_d;
    bz_q   <= bz_d;
    acc_q  <= acc_d;
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic check_en = 1'b0;

  muldiv_if #(.WIDTH(32)) bus();

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, straight from the instruction definitions.
  function automatic void model_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] h, output logic [31:0] l, output logic z);
    longint      sp;
    logic [63:0] up;
    int          sx, sy;
    h = '0; l = '0; z = 1'b0;
    sp = 0; up = '0; sx = 0; sy = 0;
    case (o)
      2'd0: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        h = sp[63:32]; l = sp[31:0];
      end
      2'd1: begin
        up = {32'b0, x} * {32'b0, y};
        h = up[63:32]; l = up[31:0];
      end
      default: begin
        if (y == 32'd0) begin
          h = x; l = 32'hFFFF_FFFF; z = 1'b1;
        end else if (o == 2'd2 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000; h = 32'd0;
        end else if (o == 2'd2) begin
          sx = x; sy = y;
          l = sx / sy; h = sx % sy;
        end else begin
          l = x / y; h = x % y;
        end
      end
    endcase
  endfunction

  logic [31:0] r_hi, r_lo;
  logic        r_z;
  always_comb model_op(bus.op, bus.a, bus.b, r_hi, r_lo, r_z);

  int          m_rem;
  logic        m_done, m_dbz;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        p_z;

  always @(posedge clk) begin
    if (!reset) begin
      m_rem <= 0; m_done <= 1'b0; m_dbz <= 1'b0; m_hi <= '0; m_lo <= '0;
    end else begin
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_hi <= p_hi; m_lo <= p_lo; m_done <= 1'b1; m_dbz <= p_z;
        end
      end else if (bus.start) begin
        m_rem <= 33; p_hi <= r_hi; p_lo <= r_lo; p_z <= r_z;
      end else begin
        if (bus.hi_we) m_hi <= bus.wdata;
        if (bus.lo_we) m_lo <= bus.wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", {63'b0, bus.busy}, {63'b0, (m_rem != 0)});
      chk("done", {63'b0, bus.done}, {63'b0, m_done});
      chk("div_by_zero", {63'b0, bus.div_by_zero}, {63'b0, m_dbz});
      chk("hi", {32'b0, bus.hi}, {32'b0, m_hi});
      chk("lo", {32'b0, bus.lo}, {32'b0, m_lo});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = k - 1;
        break;
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL %s: no done within 40 cycles, got none required one", nm);
    end
  endtask

  task automatic run_check(input string nm, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] eh, input logic [31:0] el, input logic ez);
    int lat;
    issue(o, x, y);
    wait_done(nm, lat);
    chk({nm, "_hi"}, {32'b0, bus.hi}, {32'b0, eh});
    chk({nm, "_lo"}, {32'b0, bus.lo}, {32'b0, el});
    chk({nm, "_dbz"}, {63'b0, bus.div_by_zero}, {63'b0, ez});
  endtask

  initial begin
    int          lat;
    int          npulse;
    logic [1:0]  o;
    logic [31:0] x, y;

    reset = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    @(posedge clk); #1;
    check_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("rst_busy", {63'b0, bus.busy}, 64'd0);
    chk("rst_hi", {32'b0, bus.hi}, 64'd0);
    chk("rst_lo", {32'b0, bus.lo}, 64'd0);

    // MULTU with exact latency and busy right after acceptance
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_busy", {63'b0, bus.busy}, 64'd1);
    wait_done("multu", lat);
    chk("multu_latency", 64'(lat), 64'd33);
    chk("multu_hi", {32'b0, bus.hi}, 64'hFFFF_FFFE);
    chk("multu_lo", {32'b0, bus.lo}, 64'h0000_0001);

    run_check("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_check("div_neg", 2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_check("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_check("divu_zero", 2'd3, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);

    // start in the done cycle is accepted
    bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'd6; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b_busy", {63'b0, bus.busy}, 64'd1);
    chk("b2b_done", {63'b0, bus.done}, 64'd0);
    wait_done("b2b", lat);
    chk("b2b_lo", {32'b0, bus.lo}, 64'd42);

    // idle HI/LO writes
    @(posedge clk); #1;
    bus.hi_we = 1'b1; bus.wdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    chk("mthi", {32'b0, bus.hi}, 64'h1234_5678);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hA5A5_5A5A;
    @(posedge clk); #1;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    chk("mthilo_hi", {32'b0, bus.hi}, 64'hA5A5_5A5A);
    chk("mthilo_lo", {32'b0, bus.lo}, 64'hA5A5_5A5A);

    // start while busy is ignored
    issue(2'd1, 32'd3, 32'd4);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 2'd3; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("busy_start", lat);
    chk("busy_start_lat", 64'(lat), 64'd28);
    chk("busy_start_hi", {32'b0, bus.hi}, 64'd0);
    chk("busy_start_lo", {32'b0, bus.lo}, 64'd12);

    // reset mid-operation discards everything
    issue(2'd3, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("midrst_busy", {63'b0, bus.busy}, 64'd0);
    chk("midrst_done", {63'b0, bus.done}, 64'd0);
    chk("midrst_hi", {32'b0, bus.hi}, 64'd0);
    chk("midrst_lo", {32'b0, bus.lo}, 64'd0);
    npulse = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) npulse++;
    end
    chk("midrst_no_done", 64'(npulse), 64'd0);

    // randomized operations, idle writes and start-with-write collisions
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
        bus.hi_we = 1'($urandom_range(0, 1));
        bus.lo_we = 1'($urandom_range(0, 1));
        bus.wdata = $urandom;
        @(posedge clk); #1;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      end
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = $urandom_range(1, 5);
        3: x = $urandom_range(0, 100);
        default: ;
      endcase
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
      bus.hi_we = ($urandom_range(0, 3) == 0);
      bus.lo_we = ($urandom_range(0, 3) == 0);
      bus.wdata = $urandom;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      wait_done("rand", lat);
    end

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
